// File: rtl/mbist_bg_sequencer.sv
// mbist_bg_sequencer
// ------------------
// MBIST data-background generator and sequencer. Steps through the enabled
// background patterns (BG_MASK) under a start / bg_next / done handshake and
// produces the registered write/expected data word for the march datapath.
// A manual mode selects the pattern directly, using the legacy background
// decoder encodings 0..5 plus two new row-checkerboard patterns 6 and 7.
//
// Handshake: start and bg_next are single-cycle pulses sampled on the rising
// edge. start is accepted only in IDLE. bg_next is accepted only in ACTIVE,
// where it takes priority over a simultaneous start. done is high for exactly
// the one cycle spent in DONE.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   start      pulse: begin the automatic sequence when idle
//   bg_next    pulse: current background finished
//   inv        invert the generated pattern (march w1/r1 elements)
//   addr       current memory address (bit 0 drives the checkerboard)
//   man_en     manual mode: pattern comes from man_sel
//   man_sel    manual background index
//   busy       high in ACTIVE and DONE
//   bg_valid   high in ACTIVE, bg_idx meaningful
//   bg_idx     current sequenced background index
//   done       one-cycle pulse after the last enabled background
//   data_t     registered background data word (latency 1)
//   fsm_state  debug view of the sequencer state (0 idle, 1 active, 2 done)

module mbist_bg_sequencer #(
  parameter int          DATA_W  = 8,
  parameter int          ADDR_W  = 4,
  parameter logic [7:0]  BG_MASK = 8'hFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              bg_next,
  input  logic              inv,
  input  logic [ADDR_W-1:0] addr,
  input  logic              man_en,
  input  logic [2:0]        man_sel,
  output logic              busy,
  output logic              bg_valid,
  output logic [2:0]        bg_idx,
  output logic              done,
  output logic [DATA_W-1:0] data_t,
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [2:0]  idx_nx;
  logic [2:0]  first_idx;
  logic [2:0]  next_idx;
  logic        has_next;
  logic [2:0]  sel;
  logic [DATA_W-1:0] p_alt;
  logic [DATA_W-1:0] p_half;
  logic [DATA_W-1:0] pat;

  // Only addr[0] selects the checkerboard phase; upper bits are ignored.
  logic unused_addr;
  assign unused_addr = ^addr;

  // Lowest enabled index, and the next enabled index above bg_idx.
  // Scanning downward lets the last hit be the smallest qualifying index.
  always_comb begin
    first_idx = 3'd0;
    next_idx  = bg_idx;
    has_next  = 1'b0;
    for (int j = 7; j >= 0; j--) begin
      if (BG_MASK[j]) begin
        first_idx = 3'(j);
        if (3'(j) > bg_idx) begin
          next_idx = 3'(j);
          has_next = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = bg_idx;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (BG_MASK != 8'd0) begin
            state_nx = S_ACTIVE;
            idx_nx   = first_idx;
          end else begin
            state_nx = S_DONE;
          end
        end
      end
      S_ACTIVE: begin
        if (bg_next) begin
          if (has_next) idx_nx = next_idx;
          else          state_nx = S_DONE;
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
        idx_nx   = 3'd0;
      end
      default: begin
        state_nx = S_IDLE;
        idx_nx   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      bg_idx <= 3'd0;
    end else begin
      state  <= state_nx;
      bg_idx <= idx_nx;
    end
  end

  // Pattern generator. p_alt is 1 on odd bits, p_half on the upper half.
  always_comb begin
    sel = man_en ? man_sel : bg_idx;
    for (int i = 0; i < DATA_W; i++) begin
      p_alt[i]  = i[0];
      p_half[i] = (i >= DATA_W / 2);
    end
    case (sel)
      3'd0:    pat = p_alt;
      3'd1:    pat = ~p_alt;
      3'd2:    pat = p_half;
      3'd3:    pat = ~p_half;
      3'd4:    pat = '0;
      3'd5:    pat = '1;
      3'd6:    pat = p_alt ^ {DATA_W{addr[0]}};
      default: pat = ~(p_alt ^ {DATA_W{addr[0]}});
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)                             data_t <= '0;
    else if (man_en || state == S_ACTIVE) data_t <= pat ^ {DATA_W{inv}};
    else                                  data_t <= '0;
  end

  assign busy      = (state == S_ACTIVE) || (state == S_DONE);
  assign bg_valid  = (state == S_ACTIVE);
  assign done      = (state == S_DONE);
  assign fsm_state = state;

endmodule

// File: tb/tb_mbist_bg_sequencer.sv
// Testbench for mbist_bg_sequencer. Three instances share one stimulus
// stream: u0 (8-bit, all backgrounds), u1 (8-bit, mask 0010_0101) and
// u2 (16-bit, mask 0). A behavioural model built from the enabled-index list
// predicts every output of every instance each cycle.

module tb_mbist_bg_sequencer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst     = 1'b1;
  logic       start   = 1'b0;
  logic       bg_next = 1'b0;
  logic       inv     = 1'b0;
  logic [3:0] addr    = 4'd0;
  logic       man_en  = 1'b0;
  logic [2:0] man_sel = 3'd0;

  logic        busy0, valid0, done0;
  logic [2:0]  idx0;
  logic [7:0]  data0;
  logic [1:0]  st0;
  logic        busy1, valid1, done1;
  logic [2:0]  idx1;
  logic [7:0]  data1;
  logic [1:0]  st1;
  logic        busy2, valid2, done2;
  logic [2:0]  idx2;
  logic [15:0] data2;
  logic [1:0]  st2;

  mbist_bg_sequencer #(.DATA_W(8), .ADDR_W(4), .BG_MASK(8'hFF)) u0 (
    .clk(clk), .rst(rst), .start(start), .bg_next(bg_next), .inv(inv),
    .addr(addr), .man_en(man_en), .man_sel(man_sel),
    .busy(busy0), .bg_valid(valid0), .bg_idx(idx0), .done(done0),
    .data_t(data0), .fsm_state(st0));

  mbist_bg_sequencer #(.DATA_W(8), .ADDR_W(4), .BG_MASK(8'b0010_0101)) u1 (
    .clk(clk), .rst(rst), .start(start), .bg_next(bg_next), .inv(inv),
    .addr(addr), .man_en(man_en), .man_sel(man_sel),
    .busy(busy1), .bg_valid(valid1), .bg_idx(idx1), .done(done1),
    .data_t(data1), .fsm_state(st1));

  mbist_bg_sequencer #(.DATA_W(16), .ADDR_W(4), .BG_MASK(8'h00)) u2 (
    .clk(clk), .rst(rst), .start(start), .bg_next(bg_next), .inv(inv),
    .addr(addr), .man_en(man_en), .man_sel(man_sel),
    .busy(busy2), .bg_valid(valid2), .bg_idx(idx2), .done(done2),
    .data_t(data2), .fsm_state(st2));

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         widths[3] = '{8, 8, 16};
  logic [7:0] masks[3]  = '{8'hFF, 8'h25, 8'h00};
  int         en_list[3][8];
  int         en_cnt[3];
  int         m_phase[3];   // 0 idle, 1 active, 2 done
  int         m_pos[3];
  int         m_idx[3];
  logic [15:0] m_data[3];

  // Background word from the pattern rules, bit by bit.
  function automatic logic [15:0] bg_word(input int k, input bit a, input int w, input bit iv);
    logic [15:0] r;
    bit b;
    r = '0;
    for (int i = 0; i < w; i++) begin
      case (k)
        0:       b = (i % 2 == 1);
        1:       b = (i % 2 == 0);
        2:       b = (i >= w / 2);
        3:       b = (i < w / 2);
        4:       b = 1'b0;
        5:       b = 1'b1;
        6:       b = (i % 2 == 1) ^ a;
        default: b = !((i % 2 == 1) ^ a);
      endcase
      r[i] = b ^ iv;
    end
    return r;
  endfunction

  task automatic model_init();
    for (int n = 0; n < 3; n++) begin
      en_cnt[n] = 0;
      for (int k = 0; k < 8; k++) begin
        if (masks[n][k]) begin
          en_list[n][en_cnt[n]] = k;
          en_cnt[n]++;
        end
      end
      m_phase[n] = 0;
      m_pos[n]   = 0;
      m_idx[n]   = 0;
      m_data[n]  = '0;
    end
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    for (int n = 0; n < 3; n++) begin
      if (rst) begin
        m_phase[n] = 0;
        m_idx[n]   = 0;
        m_data[n]  = '0;
      end else begin
        if (man_en || m_phase[n] == 1)
          m_data[n] = bg_word(man_en ? int'(man_sel) : m_idx[n], addr[0], widths[n], inv);
        else
          m_data[n] = '0;
        case (m_phase[n])
          0: if (start) begin
               if (en_cnt[n] > 0) begin
                 m_phase[n] = 1;
                 m_pos[n]   = 0;
                 m_idx[n]   = en_list[n][0];
               end else begin
                 m_phase[n] = 2;
               end
             end
          1: if (bg_next) begin
               if (m_pos[n] + 1 < en_cnt[n]) begin
                 m_pos[n]++;
                 m_idx[n] = en_list[n][m_pos[n]];
               end else begin
                 m_phase[n] = 2;
               end
             end
          default: begin
            m_phase[n] = 0;
            m_idx[n]   = 0;
          end
        endcase
      end
    end
  endtask

  task automatic check_inst(input int n, input logic b, input logic v, input logic [2:0] ix,
                            input logic d, input logic [15:0] dt);
    check($sformatf("u%0d.busy", n),     16'(b),  16'(m_phase[n] != 0));
    check($sformatf("u%0d.bg_valid", n), 16'(v),  16'(m_phase[n] == 1));
    check($sformatf("u%0d.bg_idx", n),   16'(ix), 16'(m_idx[n]));
    check($sformatf("u%0d.done", n),     16'(d),  16'(m_phase[n] == 2));
    check($sformatf("u%0d.data_t", n),   dt,      m_data[n]);
  endtask

  // ---------------- driver ----------------
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_inst(0, busy0, valid0, idx0, done0, 16'(data0));
    check_inst(1, busy1, valid1, idx1, done1, 16'(data1));
    check_inst(2, busy2, valid2, idx2, done2, data2);
  endtask

  logic [7:0] legacy_tbl[6] = '{8'hAA, 8'h55, 8'hF0, 8'h0F, 8'h00, 8'hFF};

  initial begin
    model_init();

    // reset
    rst = 1'b1;
    tick();
    tick();
    check("reset_data0", 16'(data0), 16'h0000);
    check("reset_idx0", 16'(idx0), 16'h0000);
    rst = 1'b0;

    // legacy encodings in manual mode
    man_en = 1'b1;
    inv    = 1'b0;
    for (int k = 0; k < 6; k++) begin
      man_sel = 3'(k);
      tick();
      check("legacy_data", 16'(data0), 16'(legacy_tbl[k]));
    end

    // row checkerboard patterns
    man_sel = 3'd6; addr = 4'd1; inv = 1'b1;
    tick();
    check("chk6_a1_inv", 16'(data0), 16'h00AA);
    addr = 4'd2;
    tick();
    check("chk6_a2_inv", 16'(data0), 16'h0055);
    man_sel = 3'd7; addr = 4'd3; inv = 1'b0;
    tick();
    check("chk7_a3", 16'(data0), 16'h00AA);
    man_sel = 3'd2;
    tick();
    check("w16_sel2", data2, 16'hFF00);
    man_en = 1'b0;
    tick();

    // automatic sequence, bg_next every 4 cycles, stray start mid-sequence
    start = 1'b1;
    tick();
    start = 1'b0;
    check("mask0_done", 16'(done2), 16'h0001);
    for (int s = 0; s < 8; s++) begin
      if (s == 1) start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      bg_next = 1'b1;
      tick();
      bg_next = 1'b0;
    end
    check("full_seq_done", 16'(done0), 16'h0001);
    tick();
    check("full_seq_idle", 16'(busy0), 16'h0000);

    // bg_next while idle
    bg_next = 1'b1;
    tick();
    bg_next = 1'b0;
    tick();

    // reset in the middle of a sequence at bg_idx 3
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int s = 0; s < 3; s++) begin
      bg_next = 1'b1;
      tick();
    end
    bg_next = 1'b0;
    check("pre_reset_idx", 16'(idx0), 16'h0003);
    man_en = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    man_en = 1'b0;
    check("mid_reset_idx", 16'(idx0), 16'h0000);
    check("mid_reset_busy", 16'(busy0), 16'h0000);
    check("mid_reset_data", 16'(data0), 16'h0000);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_valid", 16'(valid0), 16'h0001);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst     = ($urandom_range(0, 149) == 0);
      start   = ($urandom_range(0, 9) == 0);
      bg_next = ($urandom_range(0, 3) == 0);
      inv     = 1'($urandom_range(0, 1));
      addr    = 4'($urandom_range(0, 15));
      man_en  = ($urandom_range(0, 3) == 0);
      man_sel = 3'($urandom_range(0, 7));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mbist_bg_sequencer.md
Name: mbist_bg_sequencer

Overview:
Parametrised MBIST data-background generator and sequencer, successor to the fixed 3-bit/8-bit background decoder. It produces the write/expected data word for the march controller and steps through a configurable set of background patterns under a start/next/done handshake. It adds address-dependent (row-checkerboard) backgrounds, data inversion for march w1/r1 elements, and a manual-select mode compatible with the legacy decoder encodings. It sits between the MBIST FSM (march element control) and the memory write-data / comparator path.

Parameters:
DATA_W, 8, data word width; must be even and >= 2.
ADDR_W, 4, width of address input used by address-dependent patterns; >= 1.
BG_MASK, 8'hFF, bit k = 1 enables background k in automatic sequencing.

Ports:
clk  input  1  system clock, all logic rising-edge.
rst  input  1  synchronous, active-high reset.
start  input  1  one-cycle pulse; begins automatic sequence when idle.
bg_next  input  1  one-cycle pulse from march FSM; current background finished.
inv  input  1  invert generated pattern (march w1/r1 elements).
addr  input  ADDR_W  current memory address from march FSM.
man_en  input  1  manual mode: pattern selected by man_sel, not sequencer.
man_sel  input  3  manual background index (legacy q encoding).
busy  output  1  high in ACTIVE and DONE.
bg_valid  output  1  high in ACTIVE; bg_idx is meaningful.
bg_idx  output  3  current sequenced background index.
done  output  1  one-cycle pulse after last enabled background.
data_t  output  DATA_W  registered background data word.

Behaviour:
- Pattern function P(k, a), bit i of DATA_W word:
  k=0: i[0] (8-bit: 10101010). k=1: ~P(0) (01010101).
  k=2: 1 if i >= DATA_W/2 (11110000). k=3: ~P(2) (00001111).
  k=4: all 0. k=5: all 1.
  k=6: P(0) XOR a[0] (row checkerboard). k=7: ~P(6).
- Encodings 0..5 match the legacy decoder exactly; 6, 7 are new.
- data_t registered, latency 1: data_t <= P(sel, addr) XOR {DATA_W{inv}}, sel = man_en ? man_sel : bg_idx. Updated every cycle when man_en=1 or state=ACTIVE; otherwise data_t <= 0.
- FSM states IDLE, ACTIVE, DONE.
  IDLE: start=1 and BG_MASK!=0 -> bg_idx <= lowest enabled index, ACTIVE. start=1 and BG_MASK==0 -> DONE directly (bg_idx unchanged). Otherwise stay.
  ACTIVE: bg_next=1 -> if an enabled index > bg_idx exists, bg_idx <= next enabled index (skipping disabled), stay ACTIVE; else DONE. bg_next=0 -> hold.
  DONE: done=1 for exactly this cycle; next cycle IDLE, bg_idx <= 0.
- start while busy ignored; simultaneous start and bg_next in ACTIVE: bg_next acts, start ignored. bg_next in IDLE/DONE ignored.
- man_en does not affect FSM; sequencer keeps stepping while manual override drives data_t.
- Reset (any state, including mid-sequence): state IDLE, bg_idx=0, busy=0, bg_valid=0, done=0, data_t=0; next cycle honours start.
- bg_idx width fixed 3 bits; no wrap-around: sequence ends after highest enabled index.

Test Plan:
- Reset then man_en=1, man_sel=0..5, inv=0 -> data_t one cycle later = AA,55,F0,0F,00,FF (legacy compatibility, DATA_W=8).
- man_en=1, man_sel=6, addr=1 then addr=2, inv=1 -> data_t = AA then 55; man_sel=7, addr=3, inv=0 -> AA.
- BG_MASK=FF, start pulse, bg_next every 4 cycles -> bg_idx 0..7 each held 4 cycles, bg_valid high throughout, done pulses once one cycle after 8th bg_next, then busy=0.
- BG_MASK=8'b0010_0101 -> bg_idx sequence 0,2,5 then done; start asserted during ACTIVE ignored; bg_next in IDLE no effect.
- DATA_W=16, BG_MASK=0 -> start gives done next cycle, bg_valid never high; man_sel=2 -> data_t=FF00.
- Assert rst while ACTIVE at bg_idx=3 -> next cycle all outputs 0, state IDLE; new start restarts at lowest enabled index.
